// File: rtl/fp_axis_pkg.sv
// Shared types, constants and helpers for the AXI4-Stream floating-point front-end.
package fp_axis_pkg;

    typedef logic [31:0] fp_word_t;

    localparam fp_word_t FP_ONE  = 32'h3F80_0000;
    localparam fp_word_t FP_QNAN = 32'h7FC0_0000;

    // Bit offset of operand idx inside a packed operand bus of width-bit words.
    function automatic int unsigned op_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/fp_tag_fifo.sv
// Synchronous tag FIFO; fullness tracked by an explicit count, pointers wrap modulo DEPTH.
module fp_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push,
    input  logic                         pop,
    input  logic [TAG_W-1:0]             din,
    output logic [TAG_W-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    // Tag storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_axis_multi_issue.sv
// Multi-issue AXI4-Stream front-end for FP cores: issues tagged operands, returns
// in-order results with their tags through a single-stage response register.
module fp_axis_multi_issue
    import fp_axis_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_OPS = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 5
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [TAG_W-1:0]            req_tag,
    input  logic [NUM_OPS*DATA_W-1:0]   req_data,
    output logic [NUM_OPS*DATA_W-1:0]   op_tdata,
    output logic [NUM_OPS-1:0]          op_tvalid,
    input  logic [NUM_OPS-1:0]          op_tready,
    input  logic [DATA_W-1:0]           res_tdata,
    input  logic                        res_tvalid,
    output logic                        res_tready,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [DATA_W-1:0]           resp_data,
    output logic [TAG_W-1:0]            resp_tag,
    output logic [$clog2(DEPTH+1)-1:0]  inflight,
    output logic                        busy,
    output logic                        err
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [NUM_OPS-1:0] pend;
    logic               accept;
    logic               res_hs;
    logic               fifo_pop;
    logic [TAG_W-1:0]   head_tag;

    // A new request may only go out once every channel has handed off its operand.
    assign pend       = op_tvalid & ~op_tready;
    assign req_ready  = (inflight < CNT_W'(DEPTH)) && (pend == '0);
    assign accept     = req_valid && req_ready;
    assign res_tready = !resp_valid || resp_ready;
    assign res_hs     = res_tvalid && res_tready;
    assign fifo_pop   = res_hs && (inflight != '0);
    assign busy       = (inflight != '0) || (op_tvalid != '0) || resp_valid;

    fp_tag_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_tag_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (accept),
        .pop   (fifo_pop),
        .din   (req_tag),
        .dout  (head_tag),
        .count (inflight)
    );

    // Operand channels: each valid holds until its own ready, reloaded on accept.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_tvalid <= '0;
            op_tdata  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_OPS; i++) begin
                if (accept) begin
                    op_tvalid[i] <= 1'b1;
                    op_tdata[op_lsb(i, DATA_W) +: DATA_W] <= req_data[op_lsb(i, DATA_W) +: DATA_W];
                end else if (op_tready[i]) begin
                    op_tvalid[i] <= 1'b0;
                end
            end
        end
    end

    // Response register: capture result with the oldest tag, drain on resp_ready.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
        end else if (fifo_pop) begin
            resp_valid <= 1'b1;
            resp_data  <= res_tdata;
            resp_tag   <= head_tag;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    // Sticky error: a result arrived with nothing outstanding and was dropped.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err <= 1'b0;
        end else if (res_hs && (inflight == '0)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_axis_multi_issue.sv
// Randomized bench: a latency-programmable core model plus an in-order request
// scoreboard predict every registered output and both ready signals each cycle.
module tb_fp_axis_multi_issue;
    import fp_axis_pkg::*;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_OPS = 2;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TAG_W   = 5;
    localparam int unsigned CNT_W   = $clog2(DEPTH+1);

    logic                      clk = 1'b0;
    logic                      rstn = 1'b0;
    logic                      req_valid = 1'b0;
    logic                      req_ready;
    logic [TAG_W-1:0]          req_tag = '0;
    logic [NUM_OPS*DATA_W-1:0] req_data = '0;
    logic [NUM_OPS*DATA_W-1:0] op_tdata;
    logic [NUM_OPS-1:0]        op_tvalid;
    logic [NUM_OPS-1:0]        op_tready = '0;
    logic [DATA_W-1:0]         res_tdata = '0;
    logic                      res_tvalid = 1'b0;
    logic                      res_tready;
    logic                      resp_valid;
    logic                      resp_ready = 1'b0;
    logic [DATA_W-1:0]         resp_data;
    logic [TAG_W-1:0]          resp_tag;
    logic [CNT_W-1:0]          inflight;
    logic                      busy;
    logic                      err;

    fp_axis_multi_issue #(
        .DATA_W (DATA_W), .NUM_OPS (NUM_OPS), .DEPTH (DEPTH), .TAG_W (TAG_W)
    ) dut (
        .clk (clk), .rstn (rstn),
        .req_valid (req_valid), .req_ready (req_ready), .req_tag (req_tag), .req_data (req_data),
        .op_tdata (op_tdata), .op_tvalid (op_tvalid), .op_tready (op_tready),
        .res_tdata (res_tdata), .res_tvalid (res_tvalid), .res_tready (res_tready),
        .resp_valid (resp_valid), .resp_ready (resp_ready), .resp_data (resp_data), .resp_tag (resp_tag),
        .inflight (inflight), .busy (busy), .err (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } exp_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                rdy;
    } core_t;

    // Scoreboard of outstanding requests (issue order) and the core's pipeline.
    exp_t              exp_q[$];
    core_t             core_q[$];
    logic [DATA_W-1:0] chan_q0[$];
    logic [DATA_W-1:0] chan_q1[$];

    logic [NUM_OPS-1:0]        m_opv = '0;
    logic [NUM_OPS*DATA_W-1:0] m_opd = '0;
    logic                      m_rv = 1'b0;
    logic [TAG_W-1:0]          m_rtag = '0;
    logic [DATA_W-1:0]         m_rdata = '0;
    logic                      m_err = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit seen_full = 1'b0;
    bit seen_err = 1'b0;
    bit fix_req = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // The core's arithmetic, as seen by the bench: any fixed function of both operands.
    function automatic logic [DATA_W-1:0] core_f(input logic [NUM_OPS*DATA_W-1:0] ops);
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        a = ops[op_lsb(0, DATA_W) +: DATA_W];
        b = ops[op_lsb(1, DATA_W) +: DATA_W];
        return a ^ {b[15:0], b[31:16]};
    endfunction

    // One clock: check registered outputs, drive new inputs, check readies, advance model.
    task automatic step(input int p_req, input int p_opr, input int p_resv, input int p_rdy,
                        input int lat, input bit spur, input bit do_rst);
        logic               e_rr;
        logic               e_rt;
        logic               acc;
        logic               res_hs;
        logic               is_spur;
        logic [NUM_OPS-1:0] chs;
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        exp_t               e;
        @(negedge clk);
        cyc++;
        chk("op_tvalid", 64'(op_tvalid), 64'(m_opv));
        chk("op_tdata", 64'(op_tdata), 64'(m_opd));
        chk("resp_valid", 64'(resp_valid), 64'(m_rv));
        chk("resp_tag", 64'(resp_tag), 64'(m_rtag));
        chk("resp_data", 64'(resp_data), 64'(m_rdata));
        chk("inflight", 64'(inflight), 64'(exp_q.size()));
        chk("busy", 64'(busy), 64'((exp_q.size() != 0) || (m_opv != '0) || m_rv));
        chk("err", 64'(err), 64'(m_err));
        if (inflight == CNT_W'(DEPTH)) seen_full = 1'b1;
        if (err) seen_err = 1'b1;

        if (do_rst) begin
            rstn = 1'b0; req_valid = 1'b0; res_tvalid = 1'b0; op_tready = '0; resp_ready = 1'b0;
            @(posedge clk);
            #1 rstn = 1'b1;
            exp_q.delete(); chan_q0.delete(); chan_q1.delete();
            m_opv = '0; m_opd = '0; m_rv = 1'b0; m_rtag = '0; m_rdata = '0; m_err = 1'b0;
            return;
        end

        req_valid = ($urandom_range(99) < p_req);
        req_tag   = TAG_W'($urandom);
        req_data  = {$urandom, $urandom};
        if (fix_req) begin
            req_valid = 1'b1;
            req_tag   = TAG_W'(5);
            req_data  = {32'h4000_0000, FP_ONE};
            fix_req   = 1'b0;
        end
        for (int i = 0; i < NUM_OPS; i++) op_tready[i] = ($urandom_range(99) < p_opr);
        resp_ready = ($urandom_range(99) < p_rdy);
        res_tvalid = 1'b0;
        res_tdata  = $urandom;
        is_spur    = 1'b0;
        if (core_q.size() != 0 && core_q[0].rdy <= cyc && $urandom_range(99) < p_resv) begin
            res_tvalid = 1'b1;
            res_tdata  = core_q[0].data;
        end else if (spur && core_q.size() == 0 && exp_q.size() == 0 && m_opv == '0 &&
                     !req_valid && $urandom_range(99) < 40) begin
            res_tvalid = 1'b1;
            is_spur    = 1'b1;
        end
        #1;
        e_rr = (exp_q.size() < DEPTH) && ((m_opv & ~op_tready) == '0);
        e_rt = !m_rv || resp_ready;
        chk("req_ready", 64'(req_ready), 64'(e_rr));
        chk("res_tready", 64'(res_tready), 64'(e_rt));

        acc    = req_valid && e_rr;
        chs    = m_opv & op_tready;
        res_hs = res_tvalid && e_rt;

        if (chs[0]) chan_q0.push_back(m_opd[op_lsb(0, DATA_W) +: DATA_W]);
        if (chs[1]) chan_q1.push_back(m_opd[op_lsb(1, DATA_W) +: DATA_W]);
        while (chan_q0.size() != 0 && chan_q1.size() != 0) begin
            a = chan_q0.pop_front();
            b = chan_q1.pop_front();
            core_q.push_back('{data: core_f({b, a}), rdy: cyc + lat});
        end

        if (res_hs && !is_spur) void'(core_q.pop_front());
        if (res_hs && exp_q.size() == 0) begin
            m_err = 1'b1;
            if (resp_ready) m_rv = 1'b0;
        end else if (res_hs) begin
            e = exp_q.pop_front();
            m_rv = 1'b1; m_rtag = e.tag; m_rdata = e.data;
        end else if (resp_ready) begin
            m_rv = 1'b0;
        end

        if (acc) begin
            exp_q.push_back('{tag: req_tag, data: core_f(req_data)});
            m_opv = '1;
            m_opd = req_data;
        end else begin
            m_opv = m_opv & ~op_tready;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;

        // Single request through an always-ready core with latency 8.
        fix_req = 1'b1;
        step(0, 100, 100, 100, 8, 0, 0);
        repeat (16) step(0, 100, 100, 100, 8, 0, 0);
        // Back-to-back issue with results stalled: fills to DEPTH, then release.
        repeat (12) step(100, 100, 0, 100, 3, 0, 0);
        repeat (25) step(0, 100, 100, 100, 3, 0, 0);
        // Independent per-channel operand acceptance.
        repeat (60) step(60, 50, 80, 100, 4, 0, 0);
        // Consumer back-pressure on the response register.
        repeat (60) step(70, 100, 100, 20, 2, 0, 0);
        repeat (30) step(0, 100, 100, 100, 2, 0, 0);
        // Results with nothing outstanding set the sticky error; reset clears it.
        repeat (10) step(0, 100, 100, 100, 2, 1, 0);
        step(0, 100, 100, 100, 2, 0, 1);
        repeat (3) step(0, 100, 100, 100, 2, 0, 0);
        // Reset with operations in flight; their stale results later flag an error.
        repeat (3) step(100, 100, 100, 100, 8, 0, 0);
        step(0, 100, 100, 100, 8, 0, 1);
        repeat (15) step(0, 100, 100, 100, 8, 0, 0);
        step(0, 100, 100, 100, 8, 0, 1);
        // Long mixed random traffic, then drain.
        for (int k = 0; k < 400; k++) begin
            step(int'($urandom_range(100)), int'($urandom_range(40, 100)),
                 int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                 int'($urandom_range(1, 6)), 0, 0);
        end
        repeat (40) step(0, 100, 100, 100, 1, 0, 0);

        chk("full_seen", 64'(seen_full), 64'(1));
        chk("err_seen", 64'(seen_err), 64'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
